// File: rtl/data_cache.sv
// L1 data cache: tag lookup, write-allocate fill from d_in, hit/miss pulses one cycle after the sampling edge; no stall.
// Optional macro DCACHE_LRU_EN selects true-LRU replacement; default build uses a per-set round-robin pointer.
module data_cache #(
    parameter int SETS = 16,
    parameter int WAYS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   n,
    input  logic [31:0]  add_in,
    input  logic [511:0] d_in,
    output logic [31:0]  add_out,
    output logic         hit,
    output logic         miss
);
    localparam int IW = $clog2(SETS);
    localparam int WW = $clog2(WAYS);
    localparam int TW = 26 - IW;

    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-1:0] dirty_q [SETS];
    logic [TW-1:0]   tag_q   [SETS][WAYS];
    logic [511:0]    data_q  [SETS][WAYS];
`ifdef DCACHE_LRU_EN
    logic [WW-1:0]   age_q   [SETS][WAYS];
    logic [WW-1:0]   age_d   [WAYS];
    logic [WW-1:0]   lru_way;
`else
    logic [WW-1:0]   rr_q    [SETS];
    logic [WW-1:0]   rr_d;
`endif
    logic hit_q, miss_q, hit_d, miss_d;
    logic [WAYS-1:0] valid_d, dirty_d;
    logic [IW-1:0]   idx;
    logic [TW-1:0]   tg;
    logic            hit_any, inv_any, fill, clr;
    logic [WW-1:0]   hit_way, inv_way, victim, acc_way;
    logic            unused_bits;

    assign idx     = add_in[5+IW:6];
    assign tg      = add_in[31:6+IW];
    assign add_out = {add_in[31:6], 6'b0};
    assign hit     = hit_q;
    assign miss    = miss_q;

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
`ifdef DCACHE_LRU_EN
        lru_way = '0;
`endif
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tg) begin
                hit_any = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[idx][w]) begin
                inv_any = 1'b1;
                inv_way = WW'(w);
            end
`ifdef DCACHE_LRU_EN
            if (age_q[idx][w] == WW'(WAYS - 1)) lru_way = WW'(w);
`endif
        end
`ifdef DCACHE_LRU_EN
        victim = inv_any ? inv_way : lru_way;
`else
        victim = inv_any ? inv_way : rr_q[idx];
`endif
    end

    always_comb begin
        valid_d = valid_q[idx];
        dirty_d = dirty_q[idx];
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        fill    = 1'b0;
        clr     = 1'b0;
        acc_way = hit_way;
`ifdef DCACHE_LRU_EN
        age_d   = age_q[idx];
`else
        rr_d    = rr_q[idx];
`endif
        case (n)
            4'd0, 4'd1: begin
                if (hit_any) begin
                    hit_d = 1'b1;
                end else begin
                    miss_d           = 1'b1;
                    fill             = 1'b1;
                    acc_way          = victim;
                    valid_d[victim]  = 1'b1;
                    dirty_d[victim]  = 1'b0;
`ifndef DCACHE_LRU_EN
                    rr_d = rr_q[idx] + 1'b1;
`endif
                end
                if (n == 4'd1) dirty_d[acc_way] = 1'b1;
`ifdef DCACHE_LRU_EN
                for (int w = 0; w < WAYS; w++) begin
                    if (WW'(w) == acc_way)
                        age_d[w] = '0;
                    else if (age_q[idx][w] < age_q[idx][acc_way])
                        age_d[w] = age_q[idx][w] + 1'b1;
                end
`endif
            end
            4'd3: if (hit_any) begin
                valid_d[hit_way] = 1'b0;
                dirty_d[hit_way] = 1'b0;
            end
            4'd4: if (hit_any) dirty_d[hit_way] = 1'b0;
            4'd8: clr = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
`ifdef DCACHE_LRU_EN
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= WW'(w);
`else
                rr_q[s] <= '0;
`endif
            end
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
            if (clr) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                    dirty_q[s] <= '0;
`ifdef DCACHE_LRU_EN
                    for (int w = 0; w < WAYS; w++) age_q[s][w] <= WW'(w);
`else
                    rr_q[s] <= '0;
`endif
                end
            end else begin
                valid_q[idx] <= valid_d;
                dirty_q[idx] <= dirty_d;
`ifdef DCACHE_LRU_EN
                age_q[idx]   <= age_d;
`else
                rr_q[idx]    <= rr_d;
`endif
            end
        end
    end

    // Tag/data need no reset: a line is only looked at while its valid bit is set.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[idx][victim]  <= tg;
            data_q[idx][victim] <= d_in;
        end
    end

    // Line data and the byte offset have no consumer inside this block.
    always_comb begin
        unused_bits = ^add_in[5:0];
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                unused_bits = unused_bits ^ (^data_q[s][w]);
    end
endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache; replacement expectations follow DCACHE_LRU_EN.
module tb_data_cache;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   n = 4'd15;
    logic [31:0]  add_in = '0;
    logic [511:0] d_in = '0;
    logic [31:0]  add_out;
    logic         hit, miss;
    int           checks = 0;
    int           failures = 0;

    data_cache #(.SETS(16), .WAYS(4)) dut (
        .clk(clk), .rst(rst), .n(n), .add_in(add_in), .d_in(d_in),
        .add_out(add_out), .hit(hit), .miss(miss)
    );

    always #5 clk = ~clk;

    task automatic cmd(input logic [3:0] c, input logic [31:0] a);
        n      = c;
        add_in = a;
        d_in   = {16{a}};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (hit !== 1'b0 || miss !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses hit=%b miss=%b required 0/0", hit, miss);
        end
        checks++;
        if (dut.valid_q[0] !== 4'b0000 || dut.dirty_q[0] !== 4'b0000) begin
            failures++;
            $display("FAIL reset_lines valid=%b dirty=%b required 0000/0000", dut.valid_q[0], dut.dirty_q[0]);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        n = 4'd0;
        add_in = 32'h0000_1040;
        d_in = {16{add_in}};
        #1;
        checks++;
        if (add_out !== 32'h0000_1040) begin
            failures++;
            $display("FAIL add_out got=%h required 00001040", add_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (hit !== 1'b0 || miss !== 1'b1) begin
            failures++;
            $display("FAIL basic_miss hit=%b miss=%b required 0/1", hit, miss);
        end
        cmd(4'd0, 32'h0000_107C);
        checks++;
        if (hit !== 1'b1 || miss !== 1'b0) begin
            failures++;
            $display("FAIL basic_hit hit=%b miss=%b required 1/0", hit, miss);
        end
        checks++;
        if (add_out !== 32'h0000_1040) begin
            failures++;
            $display("FAIL add_out_align got=%h required 00001040", add_out);
        end
        cmd(4'd15, 32'h0000_107C);
        checks++;
        if (hit !== 1'b0 || miss !== 1'b0) begin
            failures++;
            $display("FAIL pulse_width hit=%b miss=%b required 0/0", hit, miss);
        end
    endtask

    task automatic test_write_snoop;
        cmd(4'd8, 32'h0);
        cmd(4'd1, 32'h2000_0000);
        checks++;
        if (hit !== 1'b0 || miss !== 1'b1) begin
            failures++;
            $display("FAIL wr_miss hit=%b miss=%b required 0/1", hit, miss);
        end
        checks++;
        if (dut.dirty_q[0][0] !== 1'b1 || dut.valid_q[0][0] !== 1'b1) begin
            failures++;
            $display("FAIL wr_dirty dirty=%b valid=%b required 1/1", dut.dirty_q[0][0], dut.valid_q[0][0]);
        end
        cmd(4'd4, 32'h2000_0000);
        checks++;
        if (hit !== 1'b0 || miss !== 1'b0) begin
            failures++;
            $display("FAIL snoop_pulse hit=%b miss=%b required 0/0", hit, miss);
        end
        checks++;
        if (dut.dirty_q[0][0] !== 1'b0 || dut.valid_q[0][0] !== 1'b1) begin
            failures++;
            $display("FAIL snoop_clean dirty=%b valid=%b required 0/1", dut.dirty_q[0][0], dut.valid_q[0][0]);
        end
    endtask

    task automatic test_replacement;
        logic exp_t2_hit;
        cmd(4'd8, 32'h0);
        for (int t = 1; t <= 4; t++) cmd(4'd0, 32'(t) << 10);
        cmd(4'd0, 32'h0000_0400);
        checks++;
        if (hit !== 1'b1 || miss !== 1'b0) begin
            failures++;
            $display("FAIL repl_reread1 hit=%b miss=%b required 1/0", hit, miss);
        end
        cmd(4'd0, 32'h0000_1400);
        checks++;
        if (miss !== 1'b1) begin
            failures++;
            $display("FAIL repl_tag5 miss=%b required 1", miss);
        end
`ifdef DCACHE_LRU_EN
        exp_t2_hit = 1'b0;
`else
        exp_t2_hit = 1'b1;
`endif
        cmd(4'd0, 32'h0000_0800);
        checks++;
        if (hit !== exp_t2_hit || miss !== ~exp_t2_hit) begin
            failures++;
            $display("FAIL repl_tag2 hit=%b miss=%b required %b/%b", hit, miss, exp_t2_hit, ~exp_t2_hit);
        end
        cmd(4'd0, 32'h0000_0400);
        checks++;
        if (hit !== ~exp_t2_hit || miss !== exp_t2_hit) begin
            failures++;
            $display("FAIL repl_tag1 hit=%b miss=%b required %b/%b", hit, miss, ~exp_t2_hit, exp_t2_hit);
        end
    endtask

    task automatic test_invalidate;
        cmd(4'd8, 32'h0);
        cmd(4'd0, 32'h3000_0080);
        checks++;
        if (miss !== 1'b1) begin
            failures++;
            $display("FAIL inv_first miss=%b required 1", miss);
        end
        cmd(4'd3, 32'h3000_0080);
        checks++;
        if (hit !== 1'b0 || miss !== 1'b0) begin
            failures++;
            $display("FAIL inv_pulse hit=%b miss=%b required 0/0", hit, miss);
        end
        cmd(4'd0, 32'h3000_0080);
        checks++;
        if (hit !== 1'b0 || miss !== 1'b1) begin
            failures++;
            $display("FAIL inv_reread hit=%b miss=%b required 0/1", hit, miss);
        end
        cmd(4'd0, 32'h3000_0080);
        checks++;
        if (hit !== 1'b1 || miss !== 1'b0) begin
            failures++;
            $display("FAIL inv_refill_hit hit=%b miss=%b required 1/0", hit, miss);
        end
    endtask

    task automatic test_clear_noop;
        logic [31:0] lines [3];
        lines[0] = 32'h5000_0000;
        lines[1] = 32'h5000_0040;
        lines[2] = 32'h5000_0080;
        cmd(4'd8, 32'h0);
        for (int i = 0; i < 3; i++) cmd(4'd0, lines[i]);
        cmd(4'd2, lines[0]);
        checks++;
        if (hit !== 1'b0 || miss !== 1'b0) begin
            failures++;
            $display("FAIL noop2 hit=%b miss=%b required 0/0", hit, miss);
        end
        cmd(4'd9, lines[1]);
        checks++;
        if (hit !== 1'b0 || miss !== 1'b0) begin
            failures++;
            $display("FAIL noop9 hit=%b miss=%b required 0/0", hit, miss);
        end
        cmd(4'd0, lines[0]);
        checks++;
        if (hit !== 1'b1) begin
            failures++;
            $display("FAIL noop_state hit=%b required 1", hit);
        end
        cmd(4'd8, 32'h0);
        checks++;
        if (hit !== 1'b0 || miss !== 1'b0) begin
            failures++;
            $display("FAIL clear_pulse hit=%b miss=%b required 0/0", hit, miss);
        end
        for (int i = 0; i < 3; i++) begin
            cmd(4'd0, lines[i]);
            checks++;
            if (hit !== 1'b0 || miss !== 1'b1) begin
                failures++;
                $display("FAIL clear_read%0d hit=%b miss=%b required 0/1", i, hit, miss);
            end
        end
    endtask

    task automatic test_back_to_back;
        cmd(4'd8, 32'h0);
        cmd(4'd0, 32'h6000_0140);
        checks++;
        if (miss !== 1'b1) begin
            failures++;
            $display("FAIL b2b_miss miss=%b required 1", miss);
        end
        cmd(4'd1, 32'h6000_0140);
        checks++;
        if (hit !== 1'b1 || miss !== 1'b0) begin
            failures++;
            $display("FAIL b2b_wr_hit hit=%b miss=%b required 1/0", hit, miss);
        end
        cmd(4'd0, 32'h7000_0140);
        checks++;
        if (hit !== 1'b0 || miss !== 1'b1) begin
            failures++;
            $display("FAIL b2b_other hit=%b miss=%b required 0/1", hit, miss);
        end
        cmd(4'd0, 32'h6000_0140);
        checks++;
        if (hit !== 1'b1 || miss !== 1'b0) begin
            failures++;
            $display("FAIL b2b_reread hit=%b miss=%b required 1/0", hit, miss);
        end
        checks++;
        if (dut.dirty_q[5] !== 4'b0001) begin
            failures++;
            $display("FAIL b2b_dirty got=%b required 0001", dut.dirty_q[5]);
        end
    endtask

    task automatic test_async_reset;
        cmd(4'd8, 32'h0);
        cmd(4'd0, 32'h4000_0100);
        checks++;
        if (miss !== 1'b1) begin
            failures++;
            $display("FAIL ares_setup miss=%b required 1", miss);
        end
        n = 4'd1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (hit !== 1'b0 || miss !== 1'b0) begin
            failures++;
            $display("FAIL ares_drop hit=%b miss=%b required 0/0", hit, miss);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dut.dirty_q[4] !== 4'b0000 || dut.valid_q[4] !== 4'b0000) begin
            failures++;
            $display("FAIL ares_discard dirty=%b valid=%b required 0000/0000", dut.dirty_q[4], dut.valid_q[4]);
        end
        rst = 1'b0;
        cmd(4'd0, 32'h4000_0100);
        checks++;
        if (hit !== 1'b0 || miss !== 1'b1) begin
            failures++;
            $display("FAIL ares_reread hit=%b miss=%b required 0/1", hit, miss);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_write_snoop();
        test_replacement();
        test_invalidate();
        test_clear_noop();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_cache.md
# data_cache

L1 data cache for the split-L1 trace simulator; the instruction cache and the combinational next-level model are separate blocks. It consumes one trace command per clock (`n`, `add_in`) and performs tag lookup, allocation and LRU bookkeeping. It raises a one-cycle `hit` or `miss` pulse for the statistics block. On a miss it fetches a 64-byte line from the next level over `add_out` and `d_in`.

## Interface
- `SETS`, default 16: number of sets, a power of two ≥2; index width `IW = log2(SETS)`.
- `WAYS`, default 4: associativity, a power of two ≥2.
- Address split: offset `[5:0]`, index `[5+IW:6]`, tag `[31:6+IW]`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `n`  in  4  trace command: 0 read, 1 write, 3 invalidate, 4 snoop read, 8 clear; every other code is a no-op.
- `add_in`  in  32  byte address of the command.
- `d_in`  in  512  line returned by the next level for `add_out`, valid in the same cycle.
- `add_out`  out  32  line-aligned request address, `{add_in[31:6], 6'b0}`, combinational.
- `hit`  out  1  registered one-cycle pulse, read/write hit.
- `miss`  out  1  registered one-cycle pulse, read/write miss.

## Operation
- Per line: valid, dirty, tag, 512-bit data, and an LRU age of `log2(WAYS)` bits.
- Lookup compares the tag against all valid ways of the indexed set; at most one way matches.
- Read hit: `hit` pulses; the way becomes MRU.
- Read miss: victim = lowest-index invalid way, else the way with age `WAYS-1`. Victim gets `d_in`, new tag, valid=1, dirty=0, MRU. `miss` pulses.
- Write hit: dirty=1, MRU, `hit` pulses.
- Write miss: allocate as for a read miss (write-allocate), then dirty=1. `miss` pulses.
- Invalidate (3): a matching line gets valid=0 and dirty=0. No pulse, no LRU change.
- Snoop read (4): a matching line gets dirty=0. No pulse, no LRU change.
- Clear (8): all valid and dirty bits cleared; ages reset to the way index. No pulse.
- LRU update on an access to way `w` with old age `a`: `w` gets age 0; every way with age < `a` increments; other ways are unchanged.
- Ages within a set are always a permutation of 0..WAYS-1.
- Dirty victims are dropped silently. The block has no write-back port.

## Timing
- Command and `d_in` are sampled on the same rising edge. All array updates land on that edge.
- `hit`/`miss` are high for exactly the cycle after the sampling edge. They are never both high.
- One command per cycle, back-to-back, with no stall.
- A command sees every array update made by the previous cycle's command, including in the same set.
- `add_out` tracks `add_in` combinationally at all times.
- Reset asserted: `hit`=0 and `miss`=0 immediately; all lines invalid and clean; ages = way index.
- A command sampled while `rst` is high is discarded.

## Configuration
- `DCACHE_LRU_EN` defined: true-LRU replacement as above.
- `DCACHE_LRU_EN` undefined:
  - Age storage is omitted.
  - Replacement is round-robin: one `log2(WAYS)`-bit pointer per set, used only when no way is invalid, incremented modulo WAYS after each fill.
  - Pointers reset to 0 on `rst` and on clear.
  - Hits do not affect replacement.

## Test plan
- Reset, then read `0x0000_1040` → `miss` one cycle later with `add_out=0x0000_1040`; read `0x0000_107C` → `hit`.
- Write `0x2000_0000` on an empty cache → `miss`, line dirty; snoop (4) on the same address → line clean, still valid, no pulse.
- SETS=16, WAYS=4: read tags 1..4 in set 0, re-read tag 1, read tag 5 → tag 2 is evicted. Re-read tag 2 → `miss`; tag 1 → `hit`. With `DCACHE_LRU_EN` undefined, tag 1 is evicted instead.
- Read A → `miss`; invalidate A (3) → no pulse; read A → `miss`; read A → `hit`.
- Fill 3 lines, clear (8) → every following read of those lines → `miss`. Codes 2 and 9 → no pulse, no state change.
- Assert `rst` asynchronously mid-cycle while a write is pending → `hit`/`miss` drop at once and the write is not applied; after release, the same read → `miss`.
